// File: rtl/kgprisc_trace_pkg.sv
// Shared definitions for the KGPRISC execution-trace buffer.
//   - trace_state_e : capture FSM encoding (IDLE / CAPTURE / STOPPED)
//   - FLAG_*        : bit positions of the core flags inside the 4-bit flag field
//   - REC_BASE_W    : record width without timestamp ({flags, result, instruction, instrAddr})
//   - TS_W          : timestamp width
//   - REC_W         : actual record width; grows by TS_W when KGPRISC_TRACE_TIMESTAMP_EN is defined
//   - pack_record   : builds the untimestamped record from the core outputs
package kgprisc_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_STOPPED = 2'b10
  } trace_state_e;

  localparam int FLAGS_W    = 4;
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_SIGN  = 1;
  localparam int FLAG_JUMP  = 0;

  localparam int WORD_W     = 32;
  localparam int REC_BASE_W = FLAGS_W + 3 * WORD_W;  // 100
  localparam int TS_W       = 16;

`ifdef KGPRISC_TRACE_TIMESTAMP_EN
  localparam int REC_W = REC_BASE_W + TS_W;          // 116
`else
  localparam int REC_W = REC_BASE_W;                 // 100
`endif

  // Record layout MSB..LSB: flags, result, instruction, instrAddr.
  function automatic logic [REC_BASE_W-1:0] pack_record(
    input logic [WORD_W-1:0]  addr,
    input logic [WORD_W-1:0]  instr,
    input logic [WORD_W-1:0]  res,
    input logic [FLAGS_W-1:0] flags
  );
    return {flags, res, instr, addr};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace records with a registered read-data port.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : empties the FIFO on the next edge (wins over push/pop)
//   push        : write push_data (ignored when full unless pop is also accepted)
//   push_data   : record to store
//   pop         : consume the head record (ignored when empty)
//   full, empty : status, derived from the registered count
//   count       : number of records held (0..DEPTH)
//   rd_data     : registered head record, zero while empty
//
// Handshake: the head is presented on rd_data whenever empty=0; a pop
// accepted at an edge retires that head. rd_data is recomputed from the
// next-state pointers and stored in a flop, so the consumer's pop decision
// never reaches rd_data combinationally.
module trace_fifo
  import kgprisc_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = REC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == AW'(0) + (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = rd_data_q;

  // A push into a full FIFO only lands when the head leaves the same edge;
  // the freed slot is exactly the one wr_ptr points at.
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_data_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      // Next head: forward the incoming record when it lands in the head
      // slot (FIFO empty or draining its last entry), else read memory.
      if (count_d == '0)
        rd_data_d = '0;
      else if (push_ok && (wr_ptr_q == rd_ptr_d))
        rd_data_d = push_data;
      else
        rd_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/kgprisc_trace_buffer.sv
// Execution-trace capture block for the KGPRISC core.
// Samples retired-instruction outputs, optionally keeps only taken jumps,
// buffers records in trace_fifo and drains them over a valid/ready stream.
// Optional feature macro: KGPRISC_TRACE_TIMESTAMP_EN (16-bit free-running
// cycle stamp in record bits [115:100]).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   retire_valid             : core retired an instruction this cycle
//   instrAddr, instruction,
//   result                   : retired PC, instruction word, writeback result
//   carry, zero, sign,
//   validJump                : core flags
//   start, clear             : capture control pulses (clear wins over start)
//   jump_only                : capture only records with validJump=1
//   stop_en, stop_addr       : stop capture after the record at stop_addr
//   trace_valid, trace_ready,
//   trace_data               : output record stream
//   state                    : FSM state (00 IDLE, 01 CAPTURE, 10 STOPPED)
//   drop_count               : saturating count of records lost to a full FIFO
//   fill_level               : records currently held
//
// Stream handshake: a record transfers on every rising edge where
// trace_valid && trace_ready; while trace_valid && !trace_ready, trace_data
// holds. trace_valid and trace_data depend only on flops.
module kgprisc_trace_buffer
  import kgprisc_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   retire_valid,
  input  logic [31:0]            instrAddr,
  input  logic [31:0]            instruction,
  input  logic [31:0]            result,
  input  logic                   carry,
  input  logic                   zero,
  input  logic                   sign,
  input  logic                   validJump,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   jump_only,
  input  logic                   stop_en,
  input  logic [31:0]            stop_addr,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [REC_W-1:0]       trace_data,
  output logic [1:0]             state,
  output logic [DROP_W-1:0]      drop_count,
  output logic [$clog2(DEPTH):0] fill_level
);

  trace_state_e       state_q, state_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [FLAGS_W-1:0] flags;
  logic [REC_W-1:0]   rec;
  logic               qualify;
  logic               stop_hit;
  logic               push_req;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  always_comb begin
    flags             = '0;
    flags[FLAG_CARRY] = carry;
    flags[FLAG_ZERO]  = zero;
    flags[FLAG_SIGN]  = sign;
    flags[FLAG_JUMP]  = validJump;
  end

`ifdef KGPRISC_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  // Free-running; deliberately untouched by clear so stamps stay monotonic
  // across capture sessions.
  assign ts_d = ts_q + TS_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  assign rec = {ts_q, pack_record(instrAddr, instruction, result, flags)};
`else
  assign rec = pack_record(instrAddr, instruction, result, flags);
`endif

  assign qualify  = retire_valid && (!jump_only || validJump);
  assign stop_hit = qualify && stop_en && (instrAddr == stop_addr);
  assign push_req = (state_q == ST_CAPTURE) && qualify && !clear;
  assign pop      = !fifo_empty && trace_ready;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (clear) begin
      state_d = ST_IDLE;
      drop_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (start) state_d = ST_CAPTURE;
        // The stop-matching record is still pushed on this same edge.
        ST_CAPTURE: if (stop_hit) state_d = ST_STOPPED;
        ST_STOPPED: if (start) state_d = ST_CAPTURE;
        default:    state_d = ST_IDLE;
      endcase
      // A full FIFO with a simultaneous pop still accepts the push.
      if (push_req && fifo_full && !pop && (drop_q != {DROP_W{1'b1}}))
        drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear),
    .push      (push_req),
    .push_data (rec),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_level),
    .rd_data   (trace_data)
  );

  assign trace_valid = !fifo_empty;
  assign state       = state_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_kgprisc_trace_buffer.sv
// Directed bench for kgprisc_trace_buffer: expected records are queued by
// the driver and checked by an independent monitor on the stream port.
module tb_kgprisc_trace_buffer;
  import kgprisc_trace_pkg::*;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;
  localparam int BW     = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              retire_valid = 1'b0;
  logic [31:0]       instrAddr = '0;
  logic [31:0]       instruction = '0;
  logic [31:0]       result = '0;
  logic              carry = 1'b0;
  logic              zero = 1'b0;
  logic              sign = 1'b0;
  logic              validJump = 1'b0;
  logic              start = 1'b0;
  logic              clear = 1'b0;
  logic              jump_only = 1'b0;
  logic              stop_en = 1'b0;
  logic [31:0]       stop_addr = '0;
  logic              trace_valid;
  logic              trace_ready = 1'b0;
  logic [REC_W-1:0]  trace_data;
  logic [1:0]        state;
  logic [DROP_W-1:0] drop_count;
  logic [4:0]        fill_level;

  logic [BW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  kgprisc_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .retire_valid (retire_valid),
    .instrAddr    (instrAddr),
    .instruction  (instruction),
    .result       (result),
    .carry        (carry),
    .zero         (zero),
    .sign         (sign),
    .validJump    (validJump),
    .start        (start),
    .clear        (clear),
    .jump_only    (jump_only),
    .stop_en      (stop_en),
    .stop_addr    (stop_addr),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_data   (trace_data),
    .state        (state),
    .drop_count   (drop_count),
    .fill_level   (fill_level)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog sim_time act=expired exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  // Sampled on the falling edge: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && trace_valid && trace_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rec_unexpected act=%h exp=none", trace_data[BW-1:0]);
      end else begin
        logic [BW-1:0] e;
        e = exp_q.pop_front();
        if (trace_data[BW-1:0] !== e) begin
          failures++;
          $display("FAIL rec_data act=%h exp=%h", trace_data[BW-1:0], e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ctrl(input logic s, input logic c);
    start = s;
    clear = c;
    tick();
    start = 1'b0;
    clear = 1'b0;
  endtask

  // f is {carry, zero, sign, validJump}
  task automatic drive_retire(input logic [31:0] a, input logic [3:0] f, input bit expect_push);
    retire_valid = 1'b1;
    instrAddr    = a;
    instruction  = 32'hE000_0000 | a;
    result       = ~a;
    {carry, zero, sign, validJump} = f;
    if (expect_push) exp_q.push_back({f, ~a, 32'hE000_0000 | a, a});
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(name, exp_q.size(), 0);
    tick();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    #20;
    check("rst_state", {30'd0, state}, 0);
    check("rst_valid", {31'd0, trace_valid}, 0);
    check("rst_data", trace_data[31:0], 0);
    check("rst_drop", {16'd0, drop_count}, 0);
    check("rst_fill", {27'd0, fill_level}, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // 1: start, five sequential retires, ready held high
    trace_ready = 1'b1;
    pulse_ctrl(1'b1, 1'b0);
    check("t1_state", {30'd0, state}, 32'd1);
    check("t1_valid_pre", {31'd0, trace_valid}, 0);
    for (int i = 0; i < 5; i++) begin
      drive_retire(32'(4 * i), 4'(i), 1'b1);
      if (i == 0) begin
        check("t1_valid_lat", {31'd0, trace_valid}, 1);
        check("t1_head0", trace_data[31:0], 0);
      end
    end
    wait_drain("t1_drain");
    check("t1_drop", {16'd0, drop_count}, 0);
    check("t1_fill", {27'd0, fill_level}, 0);

    // 2: jump filter, validJump only on 3rd and 7th retire
    jump_only = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2)      drive_retire(32'h100 + 32'(4 * i), 4'b1011, 1'b1);
      else if (i == 6) drive_retire(32'h100 + 32'(4 * i), 4'b0101, 1'b1);
      else             drive_retire(32'h100 + 32'(4 * i), 4'b1110, 1'b0);
    end
    jump_only = 1'b0;
    wait_drain("t2_drain");

    // 3: overflow with consumer stalled
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++)
      drive_retire(32'h200 + 32'(4 * i), 4'b0000, i < 16);
    tick();
    tick();
    check("t3_fill", {27'd0, fill_level}, 16);
    check("t3_drop", {16'd0, drop_count}, 4);
    check("t3_valid", {31'd0, trace_valid}, 1);
    check("t3_head_hold", trace_data[31:0], 32'h200);
    trace_ready = 1'b1;
    wait_drain("t3_drain");
    check("t3_fill_empty", {27'd0, fill_level}, 0);

    // 4: stop on address 0x20
    stop_en   = 1'b1;
    stop_addr = 32'h20;
    drive_retire(32'h18, 4'b0001, 1'b1);
    drive_retire(32'h1C, 4'b0010, 1'b1);
    drive_retire(32'h20, 4'b0100, 1'b1);
    check("t4_state_stop", {30'd0, state}, 32'd2);
    drive_retire(32'h24, 4'b1000, 1'b0);
    wait_drain("t4_drain");
    check("t4_state", {30'd0, state}, 32'd2);
    stop_en = 1'b0;
    pulse_ctrl(1'b1, 1'b0);
    check("t4_restart", {30'd0, state}, 32'd1);
    check("t4_drop_kept", {16'd0, drop_count}, 4);

    // 5: full FIFO, push and pop same cycle, then clear with start
    trace_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      drive_retire(32'h300 + 32'(4 * i), 4'b0000, 1'b1);
    check("t5_full", {27'd0, fill_level}, 16);
    trace_ready = 1'b1;
    drive_retire(32'h400, 4'b1111, 1'b1);
    trace_ready = 1'b0;
    check("t5_fill_same", {27'd0, fill_level}, 16);
    check("t5_drop_same", {16'd0, drop_count}, 4);
    pulse_ctrl(1'b1, 1'b1);
    exp_q.delete();
    check("t5_clr_state", {30'd0, state}, 0);
    check("t5_clr_fill", {27'd0, fill_level}, 0);
    check("t5_clr_valid", {31'd0, trace_valid}, 0);
    check("t5_clr_drop", {16'd0, drop_count}, 0);
    check("t5_clr_data", trace_data[31:0], 0);

    // 6: asynchronous reset discards buffered records at once
    pulse_ctrl(1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      drive_retire(32'h500 + 32'(4 * i), 4'b0000, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_arst_valid", {31'd0, trace_valid}, 0);
    check("t6_arst_fill", {27'd0, fill_level}, 0);
    check("t6_arst_state", {30'd0, state}, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;

`ifdef KGPRISC_TRACE_TIMESTAMP_EN
    begin
      logic [15:0] t0, t1, d;
      pulse_ctrl(1'b1, 1'b0);
      drive_retire(32'h600, 4'b0000, 1'b1);
      tick();
      tick();
      tick();
      drive_retire(32'h604, 4'b0000, 1'b1);
      t0 = trace_data[115:100];
      trace_ready = 1'b1;
      tick();
      t1 = trace_data[115:100];
      d  = t1 - t0;
      check("ts_delta", {16'd0, d}, 4);
      wait_drain("ts_drain");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kgprisc_trace_buffer.md
# kgprisc_trace_buffer

Execution-trace capture block sitting directly downstream of the KGPRISC core. Each cycle it samples the core's retired-instruction outputs (instrAddr, instruction, result, flags), optionally filters them, and buffers records in a FIFO. The buffer drains over a valid/ready stream to a debug host or logic analyser port. Its state machine supports start, stop-on-address and clear.

## Interface
- DEPTH, 16, FIFO entries; power of two, min 2
- DROP_W, 16, width of saturating dropped-record counter
- clk  in  1  system clock, shared with the core
- rst  in  1  asynchronous, active-high reset
- retire_valid  in  1  core retired an instruction this cycle; tie to core-out-of-reset
- instrAddr  in  32  PC of retired instruction
- instruction  in  32  retired instruction word
- result  in  32  ALU/writeback result
- carry, zero, sign, validJump  in  1 each  core flags
- start  in  1  pulse: begin capture
- clear  in  1  pulse: flush FIFO, zero counters, go IDLE
- jump_only  in  1  1 = capture only records with validJump=1
- stop_en  in  1  enable stop-on-address
- stop_addr  in  32  address that ends capture
- trace_valid  out  1  trace_data holds a record
- trace_ready  in  1  consumer accepts record
- trace_data  out  REC_W  {flags[3:0], result, instruction, instrAddr}; REC_W=100, 116 with timestamp
- state  out  2  00 IDLE, 01 CAPTURE, 10 STOPPED
- drop_count  out  DROP_W  records lost to full FIFO, saturating
- fill_level  out  log2(DEPTH)+1  entries held

## Operation
- Reset: state=IDLE, FIFO empty, trace_valid=0, trace_data=0, drop_count=0, fill_level=0, timestamp=0.
- IDLE: no pushes. start -> CAPTURE.
- CAPTURE: push when retire_valid && (!jump_only || validJump). If stop_en && instrAddr==stop_addr on a qualifying retire, that record is pushed, then -> STOPPED.
- STOPPED: no pushes; draining continues. start -> CAPTURE, drop_count retained.
- clear has priority over start and push in every state: FIFO emptied, drop_count=0, state=IDLE next edge. clear and start together -> IDLE.
- Push while full with no pop that cycle: record discarded, drop_count += 1, saturating at all-ones.
- Push and pop same cycle while full: both accepted, fill_level unchanged, no drop.
- Pop occurs when trace_valid && trace_ready; trace_data stable while trace_valid && !trace_ready.
- Flags field order MSB..LSB: carry, zero, sign, validJump.
- Pointers wrap modulo DEPTH; fill_level = DEPTH means full.

## Timing
- Inputs sampled on rising clk; record pushed at edge N appears with trace_valid=1 after edge N (registered output, 1-cycle latency).
- No combinational path from trace_ready to trace_valid or trace_data.
- Push into empty FIFO with concurrent pop attempt: no bypass; valid next cycle.
- State transitions take effect on the edge sampling start/clear/stop match; the stop-matching record is still captured that edge.
- Asynchronous rst mid-operation discards all buffered records immediately.

## Configuration
- KGPRISC_TRACE_TIMESTAMP_EN defined: 16-bit free-running cycle counter (reset 0, wraps at 0xFFFF, not cleared by clear) prepended as bits [115:100]; REC_W=116.
- Undefined: no counter; REC_W=100, trace_data identical to above minus timestamp.

## Structure
- Package kgprisc_trace_pkg: state encodings (IDLE, CAPTURE, STOPPED), flag bit positions, REC_W base width, timestamp width.
- One sub-module trace_fifo: synchronous FIFO, DEPTH x REC_W, push/pop/full/empty/count, registered read data. Control FSM, filter, drop counter, timestamp in top.

## Test plan
- Reset, start, 5 retires at 0x00,0x04,0x08,0x0C,0x10 with trace_ready=1 -> 5 records out in order, first trace_valid one cycle after its push, drop_count=0.
- jump_only=1, 8 retires with validJump only on 3rd and 7th -> exactly 2 records, addresses of those instructions.
- DEPTH=16, trace_ready=0, 20 retires -> fill_level=16, drop_count=4; then ready=1 -> first 16 records drain, oldest first.
- stop_en=1, stop_addr=0x20, retires 0x18,0x1C,0x20,0x24 -> 3 records, state=STOPPED, 0x24 absent.
- Full FIFO, retire and pop same cycle -> fill_level stays 16, drop_count unchanged; clear asserted with start -> state IDLE, FIFO empty, drop_count 0.
- KGPRISC_TRACE_TIMESTAMP_EN: retires on cycles 3 and 7 after reset -> timestamp fields differ by 4.
